muldiv_32: RTL

MULDIV_32 -- requirements
Module: muldiv_32

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/sign_fix_32.sv | 41 ++++
 rtl/muldiv_32.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, function codes and FSM state type for the
// 32-bit signed multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;

    // Function-select codes, matching the ALU function table
    localparam logic [4:0] FS_MUL = 5'h1E;
    localparam logic [4:0] FS_DIV = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/sign_fix_32.sv
// Combinational sign helpers for muldiv_32.
// Ports:
//   s, t           raw signed operands -> abs_s, abs_t magnitudes
//   hi, lo         unsigned iteration result
//   is_div         selects quotient/remainder fixup vs 64-bit product fixup
//   sgn_s, sgn_t   operand signs latched at start
//   fix_hi, fix_lo sign-corrected result
module sign_fix_32 (
    input  logic [31:0] s,
    input  logic [31:0] t,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic        is_div,
    input  logic        sgn_s,
    input  logic        sgn_t,
    output logic [31:0] abs_s,
    output logic [31:0] abs_t,
    output logic [31:0] fix_hi,
    output logic [31:0] fix_lo
);

    logic [63:0] neg_prod;

    always_comb begin
        // |0x80000000| stays 0x80000000, which is correct read as unsigned
        abs_s    = s[31] ? -s : s;
        abs_t    = t[31] ? -t : t;
        neg_prod = -{hi, lo};
        fix_hi   = hi;
        fix_lo   = lo;
        if (is_div) begin
            // quotient takes the product sign, remainder the dividend sign
            if (sgn_s ^ sgn_t) fix_lo = -lo;
            if (sgn_s) fix_hi = -hi;
        end else if (sgn_s ^ sgn_t) begin
            fix_hi = neg_prod[63:32];
            fix_lo = neg_prod[31:0];
        end
    end

endmodule

// File: rtl/muldiv_32.sv
// Sequential 32-bit signed multiply (shift-add) and divide (restoring).
// Ports: clk, reset (sync, active-low), start, FS (5'h1E MUL, 5'h1F DIV),
//   S, T operands; busy, done pulse, div0 flag, Y_hi/Y_lo results.
// Macro MULDIV_DIV_EN enables the divide path; without it FS=1F is ignored.
module muldiv_32
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       FS,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] Y_hi,
    output logic [WIDTH-1:0] Y_lo
);

    localparam logic [4:0] LAST = 5'(ITERS - 1);

    state_t      state;
    state_t      next_state;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        is_div;
    logic        sgn_s;
    logic        sgn_t;

    logic        mul_req;
    logic        div_req;
    logic        div_zero;
    logic        accept;
    logic [31:0] abs_s;
    logic [31:0] abs_t;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;
    logic [31:0] hi_step;
    logic [31:0] lo_step;
    logic [32:0] add;

    assign mul_req = start && (FS == FS_MUL);
`ifdef MULDIV_DIV_EN
    logic [32:0] sub;
    assign div_req  = start && (FS == FS_DIV);
    assign div_zero = div_req && (T == '0);
`else
    assign div_req  = 1'b0;
    assign div_zero = 1'b0;
`endif
    assign accept = (state == IDLE) && (mul_req || div_req);
    assign busy   = (state != IDLE);

    sign_fix_32 u_sign (
        .s      (S),
        .t      (T),
        .hi     (hi),
        .lo     (lo),
        .is_div (is_div),
        .sgn_s  (sgn_s),
        .sgn_t  (sgn_t),
        .abs_s  (abs_s),
        .abs_t  (abs_t),
        .fix_hi (fix_hi),
        .fix_lo (fix_lo)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept && !div_zero) next_state = CALC;
            CALC:    if (cnt == LAST) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One iteration step. MUL: {hi,lo} shifts right, adding mcand to hi
    // when the multiplier bit in lo[0] is set. DIV: {hi,lo} shifts left,
    // hi is the partial remainder and quotient bits enter at lo[0].
    always_comb begin
        add     = {1'b0, hi} + {1'b0, mcand};
        hi_step = {1'b0, hi[31:1]};
        lo_step = {hi[0], lo[31:1]};
        if (lo[0]) begin
            hi_step = add[32:1];
            lo_step = {add[0], lo[31:1]};
        end
`ifdef MULDIV_DIV_EN
        sub = {hi, lo[31]} - {1'b0, mcand};
        if (is_div) begin
            if (!sub[32]) begin
                hi_step = sub[31:0];
                lo_step = {lo[30:0], 1'b1};
            end else begin
                hi_step = {hi[30:0], lo[31]};
                lo_step = {lo[30:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            sgn_s  <= 1'b0;
            sgn_t  <= 1'b0;
            Y_hi   <= '0;
            Y_lo   <= '0;
            done   <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            if (accept && div_zero) begin
                Y_hi <= S;
                Y_lo <= '1;
                done <= 1'b1;
                div0 <= 1'b1;
            end else if (accept) begin
                cnt    <= '0;
                is_div <= div_req;
                sgn_s  <= S[31];
                sgn_t  <= T[31];
                hi     <= '0;
                mcand  <= div_req ? abs_t : abs_s;
                lo     <= div_req ? abs_s : abs_t;
            end
            if (state == CALC) begin
                hi  <= hi_step;
                lo  <= lo_step;
                cnt <= cnt + 5'd1;
            end
            if (state == FIX) begin
                Y_hi <= fix_hi;
                Y_lo <= fix_lo;
                done <= 1'b1;
            end
        end
    end

endmodule
